// File: rtl/dlx_bus_if.sv
// -----------------------------------------------------------------------------
// dlx_bus_if
//
// Bridges the DLX control FSM / datapath to a simple request/acknowledge
// memory bus. The control FSM raises mr or mw and holds it until it sees busy
// low. One bus cycle is then run per held request. Requests that are
// misaligned, ambiguous (mr and mw both high) or left unacknowledged for
// TIMEOUT access cycles park the block in a sticky error state. Only reset
// leaves that state.
//
// Parameters
//   TIMEOUT   number of ACCESS cycles without bus_ack before the cycle is
//             aborted (1..255)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mr, mw    memory read / write request from the control FSM
//   ao        datapath address; [23:0] used, [31:24] ignored
//   do_data   datapath MDR write data
//   di        read data returned to the datapath (holds last read value)
//   busy      combinational stall to the control FSM
//   bus_err   sticky error flag
//   bus_req   external bus cycle request
//   bus_wr    1 = write cycle, 0 = read cycle (valid while bus_req high)
//   bus_addr  latched word address
//   bus_dout  latched write data
//   bus_din   read data from memory, sampled only with bus_ack
//   bus_ack   memory completion strobe
// -----------------------------------------------------------------------------
module dlx_bus_if #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mr,
   input  logic        mw,
   input  logic [31:0] ao,
   input  logic [31:0] do_data,
   output logic [31:0] di,
   output logic        busy,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [23:0] bus_addr,
   output logic [31:0] bus_dout,
   input  logic [31:0] bus_din,
   input  logic        bus_ack
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_ERR    = 2'd3;

   // Counter value of the last ACCESS cycle allowed to go unacknowledged.
   // The counter starts at 0 in the first ACCESS cycle, so the abort happens
   // after exactly TIMEOUT access cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_reg,    state_next;
   logic [7:0]  cnt_reg,      cnt_next;
   logic [31:0] di_reg,       di_next;
   logic        bus_req_reg,  bus_req_next;
   logic        bus_wr_reg,   bus_wr_next;
   logic        bus_err_reg,  bus_err_next;
   logic [23:0] bus_addr_reg, bus_addr_next;
   logic [31:0] bus_dout_reg, bus_dout_next;

   // Exactly one request line high: a well-formed request.
   logic single_req;
   logic aligned;

   // The top address byte is not decoded on this bus.
   logic unused_ao;

   assign single_req = mr ^ mw;
   assign aligned    = (ao[1:0] == 2'b00);
   assign unused_ao  = ^ao[31:24];

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      di_next       = di_reg;
      bus_req_next  = bus_req_reg;
      bus_wr_next   = bus_wr_reg;
      bus_err_next  = bus_err_reg;
      bus_addr_next = bus_addr_reg;
      bus_dout_next = bus_dout_reg;

      case (state_reg)
         ST_IDLE: begin
            if (mr && mw) begin
               // Ambiguous request: never start a bus cycle for it.
               state_next   = ST_ERR;
               bus_err_next = 1'b1;
            end else if (single_req) begin
               if (aligned) begin
                  // Address, data and direction are frozen here and stay
                  // untouched until the cycle ends.
                  bus_addr_next = ao[23:0];
                  bus_dout_next = do_data;
                  bus_wr_next   = mw;
                  bus_req_next  = 1'b1;
                  cnt_next      = 8'd0;
                  state_next    = ST_ACCESS;
               end else begin
                  state_next   = ST_ERR;
                  bus_err_next = 1'b1;
               end
            end
         end

         ST_ACCESS: begin
            if (bus_ack) begin
               bus_req_next = 1'b0;
               // Writes leave di alone so it keeps the last read value.
               if (!bus_wr_reg) begin
                  di_next = bus_din;
               end
               state_next = ST_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               bus_req_next = 1'b0;
               bus_err_next = 1'b1;
               state_next   = ST_ERR;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         ST_DONE: begin
            // The control FSM may still be holding the request it just had
            // serviced; wait for it to drop so it is not serviced twice.
            if (!mr && !mw) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            // ST_ERR: parked until reset; requests and acks are ignored.
            bus_req_next = 1'b0;
            bus_err_next = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= 8'd0;
         di_reg       <= 32'd0;
         bus_req_reg  <= 1'b0;
         bus_wr_reg   <= 1'b0;
         bus_err_reg  <= 1'b0;
         bus_addr_reg <= 24'd0;
         bus_dout_reg <= 32'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         di_reg       <= di_next;
         bus_req_reg  <= bus_req_next;
         bus_wr_reg   <= bus_wr_next;
         bus_err_reg  <= bus_err_next;
         bus_addr_reg <= bus_addr_next;
         bus_dout_reg <= bus_dout_next;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // busy is combinational so the control FSM stalls in the same cycle it
   // raises a request, before the bus cycle has been registered.
   always_comb begin
      busy = 1'b0;
      case (state_reg)
         ST_IDLE:   busy = single_req;
         ST_ACCESS: busy = 1'b1;
         default:   busy = 1'b0;
      endcase
   end

   assign di       = di_reg;
   assign bus_err  = bus_err_reg;
   assign bus_req  = bus_req_reg;
   assign bus_wr   = bus_wr_reg;
   assign bus_addr = bus_addr_reg;
   assign bus_dout = bus_dout_reg;

endmodule

// File: tb/tb_dlx_bus_if.sv
// -----------------------------------------------------------------------------
// tb_dlx_bus_if
//
// Transaction-level bench for dlx_bus_if. Each transaction is described by
// its kind (read, write, both-requested), address, write data, how many
// access cycles the memory waits before acknowledging, and the read data.
// The expected outcome (bus_req pulse length, error flag, di contents) is
// derived from those parameters alone. A small responder in the bench
// drives bus_ack/bus_din and injects noise on them where they must be
// ignored.
// -----------------------------------------------------------------------------
module tb_dlx_bus_if;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst_n;
   logic        mr;
   logic        mw;
   logic [31:0] ao;
   logic [31:0] do_data;
   logic [31:0] di;
   logic        busy;
   logic        bus_err;
   logic        bus_req;
   logic        bus_wr;
   logic [23:0] bus_addr;
   logic [31:0] bus_dout;
   logic [31:0] bus_din;
   logic        bus_ack;

   int          n_cmp;
   int          n_bad;
   int          n_txn;

   // Reference model state
   logic [31:0] exp_di;
   bit          in_error;

   dlx_bus_if #(.TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mr       (mr),
      .mw       (mw),
      .ao       (ao),
      .do_data  (do_data),
      .di       (di),
      .busy     (busy),
      .bus_err  (bus_err),
      .bus_req  (bus_req),
      .bus_wr   (bus_wr),
      .bus_addr (bus_addr),
      .bus_dout (bus_dout),
      .bus_din  (bus_din),
      .bus_ack  (bus_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Everything the reset must clear, checked while reset is asserted.
   task automatic chk_all_zero(input string tag);
      chk({tag, "_di"},       di,              32'd0);
      chk({tag, "_busy"},     {31'd0, busy},   32'd0);
      chk({tag, "_err"},      {31'd0, bus_err}, 32'd0);
      chk({tag, "_req"},      {31'd0, bus_req}, 32'd0);
      chk({tag, "_wr"},       {31'd0, bus_wr},  32'd0);
      chk({tag, "_addr"},     {8'd0, bus_addr}, 32'd0);
      chk({tag, "_dout"},     bus_dout,        32'd0);
   endtask

   // Asserts reset between clock edges; called and returns at a negedge.
   task automatic do_reset();
      #2;
      mr      = 1'b0;
      mw      = 1'b0;
      bus_ack = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk_all_zero("rst");
      @(negedge clk);
      rst_n    = 1'b1;
      exp_di   = 32'd0;
      in_error = 1'b0;
   endtask

   // kind: 0 = read, 1 = write, 2 = mr and mw together.
   // ack_dly: number of unacknowledged access cycles before bus_ack.
   // hold: cycles the request stays high after the bus cycle finished.
   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input logic [31:0] rdata, input int hold);
      bit   legal;
      bit   fin;
      int   req_cyc;
      int   exp_req;
      logic exp_err;

      legal = (kind != 2) && (addr[1:0] == 2'b00);
      if (!legal) begin
         exp_req = 0;
         exp_err = 1'b1;
      end else if (ack_dly < TIMEOUT) begin
         exp_req = ack_dly + 1;
         exp_err = 1'b0;
      end else begin
         exp_req = TIMEOUT;
         exp_err = 1'b1;
      end

      mr      = (kind == 0) || (kind == 2);
      mw      = (kind == 1) || (kind == 2);
      ao      = addr;
      do_data = wdata;
      bus_ack = 1'b0;
      bus_din = $urandom;
      #1;
      chk("busy_idle", {31'd0, busy}, {31'd0, (kind != 2)});

      req_cyc = 0;
      fin     = 1'b0;
      for (int c = 0; c < TIMEOUT + 8 && !fin; c++) begin
         @(negedge clk);
         if (bus_req) begin
            chk("addr", {8'd0, bus_addr}, {8'd0, addr[23:0]});
            chk("wr",   {31'd0, bus_wr},  {31'd0, (kind == 1)});
            chk("dout", bus_dout, wdata);
            chk("busy_acc", {31'd0, busy}, 32'd1);
            bus_ack = (req_cyc == ack_dly);
            bus_din = (req_cyc == ack_dly) ? rdata : $urandom;
            req_cyc++;
         end else begin
            fin = 1'b1;
         end
      end
      if (!fin) chk("req_bounded", 32'd0, 32'd1);

      if (legal && exp_err == 1'b0 && kind == 0) exp_di = rdata;

      chk("req_cycles", req_cyc, exp_req);
      chk("err",  {31'd0, bus_err}, {31'd0, exp_err});
      chk("di",   di, exp_di);
      chk("busy_end", {31'd0, busy}, 32'd0);

      // Request still held (or random in the error state), ack noise.
      for (int h = 0; h < hold; h++) begin
         if (exp_err) begin
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
         end
         bus_ack = 1'($urandom_range(0, 1));
         bus_din = $urandom;
         @(negedge clk);
         chk("hold_req",  {31'd0, bus_req}, 32'd0);
         chk("hold_busy", {31'd0, busy},    32'd0);
         chk("hold_di",   di, exp_di);
         chk("hold_err",  {31'd0, bus_err}, {31'd0, exp_err});
      end

      mr      = 1'b0;
      mw      = 1'b0;
      bus_ack = 1'($urandom_range(0, 1));
      bus_din = $urandom;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("drop_req", {31'd0, bus_req}, 32'd0);
      chk("drop_di",  di, exp_di);
      chk("drop_err", {31'd0, bus_err}, {31'd0, exp_err});
      in_error = exp_err;

      n_txn++;
      $display("txn %0d kind=%0d addr=%h dly=%0d req_cycles=%0d err=%0b di=%h",
               n_txn, kind, addr, ack_dly, req_cyc, bus_err, di);
   endtask

   // Reset in the second access cycle of a read, then a late ack.
   task automatic reset_mid_access();
      mr      = 1'b1;
      mw      = 1'b0;
      ao      = 32'h0000_0040;
      do_data = 32'hA5A5_5A5A;
      @(negedge clk);                 // first ACCESS cycle
      chk("mid_req_up", {31'd0, bus_req}, 32'd1);
      @(negedge clk);                 // second ACCESS cycle
      #2;
      rst_n = 1'b0;
      mr    = 1'b0;
      #1;
      chk_all_zero("mid");
      @(negedge clk);
      rst_n   = 1'b1;
      bus_ack = 1'b1;
      bus_din = 32'hCAFE_F00D;
      @(negedge clk);
      bus_ack = 1'b0;
      @(negedge clk);
      chk("mid_di_after", di, 32'd0);
      chk("mid_req_after", {31'd0, bus_req}, 32'd0);
      chk("mid_err_after", {31'd0, bus_err}, 32'd0);
      exp_di   = 32'd0;
      in_error = 1'b0;
      n_txn++;
      $display("txn %0d reset in access, late ack ignored, di=%h", n_txn, di);
   endtask

   initial begin
      int          kind;
      int          dly;
      logic [31:0] addr;

      n_cmp    = 0;
      n_bad    = 0;
      n_txn    = 0;
      exp_di   = 32'd0;
      in_error = 1'b0;
      rst_n    = 1'b0;
      mr       = 1'b0;
      mw       = 1'b0;
      ao       = 32'd0;
      do_data  = 32'd0;
      bus_ack  = 1'b0;
      bus_din  = 32'd0;

      #3;
      chk_all_zero("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_txn(0, 32'h0000_0010, 32'h0000_0000, 3, 32'hDEAD_BEEF, 2);
      run_txn(1, 32'hFF00_0020, 32'h1234_5678, 0, 32'h0BAD_0BAD, 1);
      run_txn(0, 32'h0000_0030, 32'h0000_0000, 5, 32'h1111_2222, 5);
      run_txn(0, 32'h0000_0044, 32'h0000_0000, 40, 32'h0, 3);
      do_reset();
      run_txn(0, 32'h0000_0013, 32'h0000_0000, 0, 32'h0, 2);
      do_reset();
      run_txn(2, 32'h0000_0020, 32'h0000_0000, 0, 32'h0, 2);
      do_reset();
      run_txn(0, 32'h0000_0100, 32'h0000_0000, TIMEOUT - 1, 32'h7777_8888, 1);
      reset_mid_access();

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         if (in_error) do_reset();
         kind = ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 9) != 0) addr[1:0] = 2'b00;
         dly  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                            : int'($urandom_range(0, 6));
         run_txn(kind, addr, $urandom, dly, $urandom, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute guard against a stuck run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
